// File: rtl/image_stream_out.sv
// image_stream_out: reads a frame of 128-bit words from the new-image RAM and
// serialises every word into a byte stream, least-significant byte first.
//
// Handshake: a byte moves on a rising clk edge where m_valid && m_ready.
// Once m_valid is raised, m_data and m_last stay constant until that transfer.
// m_valid never drops without a transfer, except on reset. m_valid, m_data and
// m_last come straight from registers, so there is no combinational path from
// m_ready to them.
module image_stream_out #(
  parameter int NUM_WORDS = 4096,
  parameter int ADDR_W    = 13,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [127:0]      mem_rd_data,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [1:0]        LAT_INIT  = 2'(RD_LAT - 1);

  logic [2:0]   state;
  logic [3:0]   byte_cnt;
  logic [1:0]   lat_cnt;
  logic [127:0] shift_reg;
  logic         last_word;
  logic         xfer;

  // mem_addr doubles as the word index, so it is the only word counter
  assign last_word = (mem_addr == LAST_ADDR);
  assign xfer      = m_valid && m_ready;
  assign fsm_state = state;

  // Readout sequencer: fetch a word, wait for RAM latency, stream 16 bytes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_cnt  <= 4'd0;
      lat_cnt   <= 2'd0;
      shift_reg <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_FETCH;
            mem_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_FETCH: begin
          state   <= S_WAIT;
          lat_cnt <= LAT_INIT;
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            // RAM output now reflects mem_addr; load the word and present byte 0
            state     <= S_SEND;
            shift_reg <= mem_rd_data;
            m_data    <= mem_rd_data[7:0];
            m_valid   <= 1'b1;
            m_last    <= 1'b0;
            byte_cnt  <= 4'd0;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_SEND: begin
          if (xfer) begin
            if (byte_cnt == 4'd15) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              if (last_word) begin
                state    <= S_DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                mem_addr <= '0;
              end else begin
                state    <= S_FETCH;
                mem_addr <= mem_addr + ADDR_W'(1);
              end
            end else begin
              shift_reg <= shift_reg >> 8;
              m_data    <= shift_reg[15:8];
              byte_cnt  <= byte_cnt + 4'd1;
              m_last    <= last_word && (byte_cnt == 4'd14);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_out.sv
// Bench for image_stream_out: two instances (RD_LAT=1 and RD_LAT=3) on a
// 4-word frame share start, reset and m_ready. Expected bytes are queued when a
// frame is started and popped as each instance transfers.
module tb_image_stream_out;

  localparam int NW = 4;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic m_ready = 1'b1;

  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [127:0]  rd_a, rd_b;
  logic [7:0]    m_data_a, m_data_b;
  logic          m_valid_a, m_valid_b, m_last_a, m_last_b;
  logic          busy_a, busy_b, done_a, done_b;
  logic [2:0]    fsm_a, fsm_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int e0 = 0;
  int first_a = -1, first_b = -1, last_a = -1, last_b = -1;
  bit found;

  logic [8:0]    exp_qa[$];
  logic [8:0]    exp_qb[$];
  logic [AW-1:0] addr_qa[$];
  logic [AW-1:0] prev_addr_a = '0;
  logic          stall_a = 1'b0, stall_b = 1'b0;
  logic [8:0]    hold_a = '0, hold_b = '0;

  // clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  image_stream_out #(.NUM_WORDS(NW), .ADDR_W(AW), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr_a),
    .mem_rd_data(rd_a), .m_data(m_data_a), .m_valid(m_valid_a),
    .m_ready(m_ready), .m_last(m_last_a), .busy(busy_a), .done(done_a),
    .fsm_state(fsm_a)
  );

  image_stream_out #(.NUM_WORDS(NW), .ADDR_W(AW), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr_b),
    .mem_rd_data(rd_b), .m_data(m_data_b), .m_valid(m_valid_b),
    .m_ready(m_ready), .m_last(m_last_b), .busy(busy_b), .done(done_b),
    .fsm_state(fsm_b)
  );

  // RAM content: word w holds bytes 16w..16w+15, byte k at bits [8k+7:8k]
  function automatic logic [127:0] ram_word(input logic [AW-1:0] a);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(16 * int'(a) + k);
    return w;
  endfunction

  // RAM models: address register, then RD_LAT-1 output stages
  logic [AW-1:0] aq_a, aq_b;
  logic [127:0]  pipe_b0, pipe_b1;
  always @(posedge clk) begin
    aq_a    <= mem_addr_a;
    aq_b    <= mem_addr_b;
    pipe_b0 <= ram_word(aq_b);
    pipe_b1 <= pipe_b0;
  end
  assign rd_a = ram_word(aq_a);
  assign rd_b = pipe_b1;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endfunction

  // scoreboard / monitor for the RD_LAT=1 instance
  always @(negedge clk) begin
    if (reset) begin
      exp_qa.delete();
      addr_qa.delete();
      stall_a = 1'b0;
      prev_addr_a = '0;
    end else begin
      if (stall_a) chk("stall_hold_a", 32'({m_valid_a, m_last_a, m_data_a}), 32'({1'b1, hold_a}));
      if (mem_addr_a != prev_addr_a) begin
        chk("addr_expected_a", 32'(addr_qa.size() != 0), 1);
        if (addr_qa.size() != 0) chk("addr_seq_a", 32'(mem_addr_a), 32'(addr_qa.pop_front()));
        chk("addr_range_a", 32'(mem_addr_a <= AW'(NW - 1)), 1);
        prev_addr_a = mem_addr_a;
      end
      if (m_valid_a && first_a < 0) first_a = cyc;
      if (m_valid_a && m_ready) begin
        chk("byte_expected_a", 32'(exp_qa.size() != 0), 1);
        if (exp_qa.size() != 0) chk("byte_a", 32'({m_last_a, m_data_a}), 32'(exp_qa.pop_front()));
        if (m_last_a) last_a = cyc + 1;
      end
      stall_a = m_valid_a && !m_ready;
      hold_a  = {m_last_a, m_data_a};
    end
  end

  // scoreboard / monitor for the RD_LAT=3 instance
  always @(negedge clk) begin
    if (reset) begin
      exp_qb.delete();
      stall_b = 1'b0;
    end else begin
      if (stall_b) chk("stall_hold_b", 32'({m_valid_b, m_last_b, m_data_b}), 32'({1'b1, hold_b}));
      if (m_valid_b && first_b < 0) first_b = cyc;
      if (m_valid_b && m_ready) begin
        chk("byte_expected_b", 32'(exp_qb.size() != 0), 1);
        if (exp_qb.size() != 0) chk("byte_b", 32'({m_last_b, m_data_b}), 32'(exp_qb.pop_front()));
        if (m_last_b) last_b = cyc + 1;
      end
      stall_b = m_valid_b && !m_ready;
      hold_b  = {m_last_b, m_data_b};
    end
  end

  // driver: queue a whole frame of expected bytes and address steps
  task automatic push_frame();
    for (int w = 0; w < NW; w++) begin
      for (int k = 0; k < 16; k++) begin
        exp_qa.push_back({(w == NW - 1 && k == 15), 8'(16 * w + k)});
        exp_qb.push_back({(w == NW - 1 && k == 15), 8'(16 * w + k)});
      end
    end
    for (int w = 1; w < NW; w++) addr_qa.push_back(AW'(w));
    addr_qa.push_back('0);
    first_a = -1; first_b = -1; last_a = -1; last_b = -1;
  endtask

  // driver: one-cycle start pulse, sampled at edge e0
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    e0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit bp);
    int n;
    n = 0;
    while (!(done_a && done_b) && n < budget) begin
      @(posedge clk); #1;
      if (bp) m_ready = ($urandom_range(0, 99) < 40);
      n++;
    end
    chk("frame_done", 32'({done_a, done_b}), 3);
    m_ready = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", 32'({m_valid_a, m_last_a, busy_a, done_a, m_data_a}), 0);
    chk("rst_addr_a", 32'(mem_addr_a), 0);
    chk("rst_b", 32'({m_valid_b, m_last_b, busy_b, done_b, m_data_b}), 0);
    reset = 1'b0;

    // basic frame, with start pulses while busy at E10 and E40
    push_frame();
    @(posedge clk); #1;
    start = 1'b1;
    e0 = cyc + 1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      start = (cyc == e0 + 9 || cyc == e0 + 39);
      if (cyc == e0 + 1) chk("e1_busy_a", 32'({busy_a, done_a, m_valid_a}), 4);
      if (cyc == e0 + 71) chk("e71_last_a", 32'({m_valid_a, m_last_a, m_data_a}), 32'h33F);
      if (cyc == e0 + 72) begin
        chk("e72_done_a", 32'({done_a, busy_a, m_valid_a, m_last_a}), 8);
        chk("e72_addr_a", 32'(mem_addr_a), 0);
      end
      if (done_a && done_b) break;
    end
    start = 1'b0;
    chk("frame_done_basic", 32'({done_a, done_b}), 3);
    chk("first_valid_a", 32'(first_a), 32'(e0 + 2));
    chk("last_xfer_a", 32'(last_a), 32'(e0 + 72));
    chk("first_valid_b", 32'(first_b), 32'(e0 + 4));
    chk("last_xfer_b", 32'(last_b), 32'(e0 + 80));
    chk("qa_empty_basic", exp_qa.size(), 0);
    chk("qb_empty_basic", exp_qb.size(), 0);
    chk("addr_q_empty_basic", addr_qa.size(), 0);

    // backpressure frame, restarted from DONE
    push_frame();
    pulse_start();
    wait_done(1500, 1'b1);
    chk("qa_empty_bp", exp_qa.size(), 0);
    chk("qb_empty_bp", exp_qb.size(), 0);
    chk("addr_q_empty_bp", addr_qa.size(), 0);

    // restart from DONE with start held for three edges
    push_frame();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("restart_done_clr_a", 32'({done_a, busy_a}), 1);
    chk("restart_done_clr_b", 32'({done_b, busy_b}), 1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(300, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("no_second_run_a", 32'({busy_a, done_a, m_valid_a}), 2);
    chk("no_second_run_b", 32'({busy_b, done_b, m_valid_b}), 2);
    chk("qa_empty_restart", exp_qa.size(), 0);
    chk("qb_empty_restart", exp_qb.size(), 0);

    // reset mid-stream on byte 5 of word 2 with the sink stalled
    push_frame();
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (m_valid_a && m_data_a == 8'h25) begin
        m_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
    chk("reset_target_found", 32'(found), 1);
    @(negedge clk); #2;
    chk("pre_reset_a", 32'({m_valid_a, busy_a, m_data_a}), 32'h325);
    reset = 1'b1;
    #1;
    chk("async_rst_a", 32'({m_valid_a, m_last_a, busy_a, done_a, m_data_a}), 0);
    chk("async_rst_addr_a", 32'(mem_addr_a), 0);
    chk("async_rst_b", 32'({m_valid_b, m_last_b, busy_b, done_b}), 0);
    chk("async_rst_addr_b", 32'(mem_addr_b), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_after_rst_a", 32'({busy_a, done_a, m_valid_a, mem_addr_a}), 0);
    chk("idle_after_rst_b", 32'({busy_b, done_b, m_valid_b, mem_addr_b}), 0);

    // fresh frame after reset resumes from byte 0x00
    push_frame();
    pulse_start();
    wait_done(300, 1'b0);
    chk("first_valid_a_post_rst", 32'(first_a), 32'(e0 + 2));
    chk("last_xfer_a_post_rst", 32'(last_a), 32'(e0 + 72));
    chk("qa_empty_post_rst", exp_qa.size(), 0);
    chk("qb_empty_post_rst", exp_qb.size(), 0);
    chk("addr_q_empty_post_rst", addr_qa.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
